// File: rtl/ook_pkg.sv
// Shared definitions for the OOK blink-pattern transmitter and receiver.
package ook_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        RX
    } ook_state_e;

    localparam logic [31:0] OOK_PATTERN  = 32'h05477715;
    localparam int unsigned OOK_GAP_BITS = 5;

    function automatic logic ook_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ook_sync_filter.sv
// Input synchronizer, optional 3-tap majority glitch filter and edge detect for the OOK receiver.
// Filter enabled by defining OOK_RX_GLITCH_FILTER_EN.
module ook_sync_filter
    import ook_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

`ifdef OOK_RX_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Majority is registered, so a step needs two agreeing taps plus one flop: +2 cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= ook_maj3(sync_q[1], hist_q[0], hist_q[1]);
        end
    end

    assign rx_s_o = filt_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s_o = sync_q[1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= rx_s_o;
        end
    end

    assign rise_o = rx_s_o & ~prev_q;
    assign fall_o = ~rx_s_o & prev_q;

endmodule

// File: rtl/ook_pattern_rx.sv
// OOK blink-pattern receiver: recovers bit timing from edges and reassembles gap-delimited frames.
// Define OOK_RX_GLITCH_FILTER_EN to insert a majority glitch filter after the synchronizer.
module ook_pattern_rx
    import ook_pkg::*;
#(
    parameter int unsigned            BIT_CYCLES = 2097152,
    parameter int unsigned            GAP_BITS   = OOK_GAP_BITS,
    parameter int unsigned            FRAME_BITS = 32,
    parameter logic [FRAME_BITS-1:0]  EXPECTED   = OOK_PATTERN
) (
    input  logic                         CLK,
    input  logic                         RESETB,
    input  logic                         RX_IN,
    output logic                         FRAME_VALID,
    output logic [FRAME_BITS-1:0]        FRAME_DATA,
    output logic [$clog2(FRAME_BITS):0]  FRAME_LEN,
    output logic                         FRAME_MATCH,
    output logic                         FRAME_ERR
);

    localparam int unsigned PH_W       = $clog2(BIT_CYCLES);
    localparam int unsigned GAP_CYCLES = GAP_BITS * BIT_CYCLES;
    localparam int unsigned GC_W       = $clog2(GAP_CYCLES);
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS) + 1;
    localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
    localparam int unsigned ZR_W       = $clog2(GAP_BITS + 1);

    localparam logic [PH_W-1:0]  SAMPLE_PH = PH_W'(BIT_CYCLES / 2 - 1);
    localparam logic [GC_W-1:0]  GAP_LAST  = GC_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [ZR_W-1:0]  ZR_LAST   = ZR_W'(GAP_BITS - 1);

    logic rx_s;
    logic rise;
    logic fall;

    ook_sync_filter u_sync (
        .clk_i  (CLK),
        .rst_ni (RESETB),
        .rx_i   (RX_IN),
        .rx_s_o (rx_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    ook_state_e             state_q;
    logic [GC_W-1:0]        gap_cnt_q;
    logic [PH_W-1:0]        phase_q;
    logic [CNT_W-1:0]       bitcnt_q;
    logic [ZR_W-1:0]        zrun_q;
    logic [FRAME_BITS-1:0]  data_q;
    logic [CNT_W-1:0]       len_q;

    logic                   valid_q;
    logic [FRAME_BITS-1:0]  frame_data_q;
    logic [CNT_W-1:0]       frame_len_q;
    logic                   match_q;
    logic                   err_q;

    logic                   sample_hit;
    logic                   frame_done;
    logic                   overflow;
    logic [FRAME_BITS-1:0]  data_d;

    // A resync edge suppresses the sample that would otherwise land in the same cycle.
    always_comb begin
        sample_hit = (state_q == RX) && !(rise || fall) && (phase_q == SAMPLE_PH);
        frame_done = sample_hit && !rx_s && (zrun_q == ZR_LAST);
        overflow   = sample_hit && (bitcnt_q == BIT_LAST) && !frame_done;
        data_d     = data_q;
        data_d[bitcnt_q[IDX_W-1:0]] = rx_s;
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            phase_q      <= '0;
            bitcnt_q     <= '0;
            zrun_q       <= '0;
            data_q       <= '0;
            len_q        <= '0;
            valid_q      <= 1'b0;
            frame_data_q <= '0;
            frame_len_q  <= '0;
            match_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_s) begin
                        gap_cnt_q <= '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_q   <= HUNT;
                        gap_cnt_q <= '0;
                        phase_q   <= '0;
                        bitcnt_q  <= '0;
                        zrun_q    <= '0;
                        data_q    <= '0;
                        len_q     <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                HUNT: begin
                    if (rise) begin
                        state_q  <= RX;
                        phase_q  <= '0;
                        bitcnt_q <= '0;
                        zrun_q   <= '0;
                        data_q   <= '0;
                        len_q    <= '0;
                    end
                end
                RX: begin
                    if (rise || fall) begin
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                    if (sample_hit) begin
                        data_q   <= data_d;
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (rx_s) begin
                            zrun_q <= '0;
                            len_q  <= bitcnt_q + 1'b1;
                        end else begin
                            zrun_q <= zrun_q + 1'b1;
                        end
                    end
                    // Completion wins over overflow when both land on the last sample slot.
                    if (frame_done) begin
                        state_q      <= HUNT;
                        valid_q      <= 1'b1;
                        frame_data_q <= data_q;
                        frame_len_q  <= len_q;
                        match_q      <= (data_q == EXPECTED) && (len_q != '0);
                        phase_q      <= '0;
                        bitcnt_q     <= '0;
                        zrun_q       <= '0;
                        data_q       <= '0;
                        len_q        <= '0;
                    end else if (overflow) begin
                        state_q   <= IDLE;
                        err_q     <= 1'b1;
                        gap_cnt_q <= '0;
                        data_q    <= '0;
                        len_q     <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign FRAME_VALID = valid_q;
    assign FRAME_DATA  = frame_data_q;
    assign FRAME_LEN   = frame_len_q;
    assign FRAME_MATCH = match_q;
    assign FRAME_ERR   = err_q;

endmodule

// File: tb/tb_ook_pattern_rx.sv
// Directed plus randomized bench for ook_pattern_rx at 8 clock cycles per bit.
module tb_ook_pattern_rx;
    import ook_pkg::*;

    localparam int unsigned BC = 8;

    logic        CLK = 1'b0;
    logic        RESETB = 1'b0;
    logic        RX_IN = 1'b0;
    logic        FRAME_VALID;
    logic [31:0] FRAME_DATA;
    logic [5:0]  FRAME_LEN;
    logic        FRAME_MATCH;
    logic        FRAME_ERR;

    ook_pattern_rx #(
        .BIT_CYCLES (BC),
        .GAP_BITS   (5),
        .FRAME_BITS (32),
        .EXPECTED   (32'h05477715)
    ) dut (
        .CLK         (CLK),
        .RESETB      (RESETB),
        .RX_IN       (RX_IN),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_DATA  (FRAME_DATA),
        .FRAME_LEN   (FRAME_LEN),
        .FRAME_MATCH (FRAME_MATCH),
        .FRAME_ERR   (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
        logic        match;
        int unsigned cyc;
    } obs_t;

    obs_t        obs_q[$];
    int unsigned cycle = 0;
    int unsigned n_valid = 0;
    int unsigned n_err = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    // Observed frames are captured mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        cycle++;
        if (FRAME_VALID === 1'b1) begin
            obs_q.push_back('{data: FRAME_DATA, len: FRAME_LEN, match: FRAME_MATCH, cyc: cycle});
            n_valid++;
        end
        if (FRAME_ERR === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: length is the position of the highest 1 plus one.
    function automatic int unsigned ref_len(input logic [31:0] w);
        int unsigned l = 0;
        for (int unsigned i = 0; i < 32; i++) if (w[i]) l = i + 1;
        return l;
    endfunction

    task automatic drive_bit(input logic b, input int unsigned cpb, input bit glitch);
        for (int unsigned c = 0; c < cpb; c++) begin
            @(negedge CLK);
            RX_IN = b | (glitch & ~b & (c == 1));
        end
    endtask

    task automatic idle_low(input int unsigned n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int unsigned cpb, input bit glitch,
                              output int unsigned t_fall);
        int unsigned n = ref_len(w);
        for (int unsigned i = 0; i < n; i++) drive_bit(w[i], cpb, glitch);
        @(negedge CLK);
        RX_IN  = 1'b0;
        t_fall = cycle;
        idle_low(55);
    endtask

    task automatic expect_frame(input string tag, input logic [31:0] w, input int unsigned t_fall);
        obs_t        f;
        int unsigned l = ref_len(w);
        int unsigned lat;
        check({tag, " count"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            f   = obs_q.pop_front();
            lat = f.cyc - t_fall;
            check({tag, " data"}, f.data, w);
            check({tag, " len"}, f.len, l);
            check({tag, " match"}, f.match, (w == OOK_PATTERN) && (l != 0));
            check({tag, " latency"}, (lat >= 35) && (lat <= 43), 1);
        end
        obs_q.delete();
    endtask

    initial begin
        int unsigned t;
        int unsigned v0;
        int unsigned e0;
        logic [31:0] w;
        int unsigned run;
        int unsigned cpb;
        logic        b;

        // Reset state
        RESETB = 1'b0;
        RX_IN  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst valid", FRAME_VALID, 0);
        check("rst data", FRAME_DATA, 0);
        check("rst len", FRAME_LEN, 0);
        check("rst match", FRAME_MATCH, 0);
        check("rst err", FRAME_ERR, 0);
        @(negedge CLK);
        RESETB = 1'b1;

        // Nominal frame, then bit-rate mismatch
        idle_low(48);
        send_frame(OOK_PATTERN, 8, 0, t);
        expect_frame("exp8", OOK_PATTERN, t);
        send_frame(OOK_PATTERN, 7, 0, t);
        expect_frame("exp7", OOK_PATTERN, t);
        send_frame(OOK_PATTERN, 9, 0, t);
        expect_frame("exp9", OOK_PATTERN, t);

        // Short frame 1,0,1: old outputs held until the new completion
        v0 = n_valid;
        drive_bit(1'b1, BC, 0);
        drive_bit(1'b0, BC, 0);
        drive_bit(1'b1, BC, 0);
        @(negedge CLK);
        RX_IN = 1'b0;
        t = cycle;
        idle_low(15);
        check("short hold data", FRAME_DATA, OOK_PATTERN);
        check("short hold valid", n_valid - v0, 0);
        idle_low(40);
        expect_frame("short", 32'h5, t);

        // Stuck high: one overflow error, outputs untouched
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
        check("stuck err", n_err - e0, 1);
        check("stuck valid", n_valid - v0, 0);
        check("stuck data", FRAME_DATA, 32'h5);
        check("stuck len", FRAME_LEN, 3);
        idle_low(48);
        check("stuck gap valid", n_valid - v0, 0);
        send_frame(OOK_PATTERN, 8, 0, t);
        expect_frame("post err", OOK_PATTERN, t);

        // Reset mid-frame
        v0 = n_valid;
        e0 = n_err;
        w  = OOK_PATTERN;
        for (int unsigned i = 0; i < 10; i++) drive_bit(w[i], BC, 0);
        @(negedge CLK);
        RESETB = 1'b0;
        @(negedge CLK);
        check("midrst data", FRAME_DATA, 0);
        check("midrst len", FRAME_LEN, 0);
        check("midrst match", FRAME_MATCH, 0);
        @(negedge CLK);
        RESETB = 1'b1;
        RX_IN  = 1'b0;
        idle_low(48);
        check("midrst valid", n_valid - v0, 0);
        check("midrst err", n_err - e0, 0);
        send_frame(OOK_PATTERN, 8, 0, t);
        expect_frame("post rst", OOK_PATTERN, t);

        // One-cycle glitches early in each low bit
        send_frame(OOK_PATTERN, 8, 1, t);
        expect_frame("glitch", OOK_PATTERN, t);

        // Random frames, runs limited to 3 equal bits, random rate 7..9 cycles/bit
        for (int k = 0; k < 8; k++) begin
            w      = '0;
            w[0]   = 1'b1;
            run    = 1;
            for (int unsigned i = 1; i < 27; i++) begin
                b = 1'($urandom_range(0, 1));
                if (b == w[i-1] && run == 3) b = ~w[i-1];
                run  = (b == w[i-1]) ? run + 1 : 1;
                w[i] = b;
            end
            w   = w & ((32'h1 << $urandom_range(1, 27)) - 1);
            cpb = $urandom_range(7, 9);
            send_frame(w, cpb, 0, t);
            expect_frame($sformatf("rand%0d", k), w, t);
        end

        check("final err count", n_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
